// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I integer register file.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rv_reg_cell.sv
// Single architectural register: async active-low clear, synchronous load.
module rv_reg_cell
    import rv_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  xlen_t d,
    output xlen_t q
);

    // Clear on reset, otherwise load d when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rv_register_file.sv
// RV32I register file: two combinational read ports, one clocked write port,
// x0 hardwired to zero.
module rv_register_file
    import rv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  reg_addr_t rd_addr,
    input  xlen_t     write_data,
    input  logic      write_enable,
    output xlen_t     rs1_data,
    output xlen_t     rs2_data
);

    // x[0] is a constant zero rather than storage so the read selects can
    // index the full address range without going out of bounds.
    xlen_t x [0:NUM_REGS-1];

    assign x[0] = '0;

    genvar i;
    generate
        for (i = 1; i < NUM_REGS; i++) begin : g_regs
            rv_reg_cell u_cell (
                .clk (clk),
                .rst (rst),
                .en  (write_enable && (rd_addr == reg_addr_t'(i))),
                .d   (write_data),
                .q   (x[i])
            );
        end
    endgenerate

    // No write-through bypass: a same-cycle write is visible only after the edge.
    assign rs1_data = (rs1_addr == REG_ZERO) ? '0 : x[rs1_addr];
    assign rs2_data = (rs2_addr == REG_ZERO) ? '0 : x[rs2_addr];

endmodule

// File: tb/tb_rv_register_file.sv
// Directed self-checking bench for rv_register_file.
module tb_rv_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int checks   = 0;
    int failures = 0;

    rv_register_file dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pattern(input int unsigned idx);
        return (idx == 0) ? 32'h0 : (32'hA5A5_0000 + idx);
    endfunction

    initial begin
        // Step 1: reset
        rst          = 1'b0;
        rs1_addr     = 5'd5;
        rs2_addr     = 5'd9;
        rd_addr      = 5'd0;
        write_data   = 32'h0;
        write_enable = 1'b0;
        #2;
        check("reset_rs1_during", rs1_data, 32'h0);
        check("reset_rs2_during", rs2_data, 32'h0);
        #8;
        rst = 1'b1;
        #1;
        check("reset_rs1_after", rs1_data, 32'h0);
        check("reset_rs2_after", rs2_data, 32'h0);

        // Step 2: write to x0 is discarded
        rd_addr      = 5'd0;
        write_data   = 32'h0000_1234;
        write_enable = 1'b1;
        rs1_addr     = 5'd0;
        tick();
        check("x0_write_discard", rs1_data, 32'h0);

        // Step 3: enabled write
        rd_addr    = 5'd4;
        write_data = 32'h0000_1234;
        tick();
        write_enable = 1'b0;
        rs1_addr     = 5'd4;
        rs2_addr     = 5'd0;
        #1;
        check("write_x4_rs1", rs1_data, 32'h0000_1234);
        check("write_x4_rs2_x0", rs2_data, 32'h0);

        // Step 4: disabled write leaves register unchanged
        write_data   = 32'hDEAD_BEEF;
        write_enable = 1'b0;
        tick();
        check("disabled_write", rs1_data, 32'h0000_1234);

        // Step 4b: read old value before edge, new value after
        write_data   = 32'h5555_AAAA;
        write_enable = 1'b1;
        #1;
        check("no_bypass_pre_edge", rs1_data, 32'h0000_1234);
        tick();
        check("post_edge_new_value", rs1_data, 32'h5555_AAAA);
        write_enable = 1'b0;

        // Step 5: fill all registers
        for (int unsigned i = 1; i < 32; i++) begin
            rd_addr      = 5'(i);
            write_data   = pattern(i);
            write_enable = 1'b1;
            tick();
        end
        write_enable = 1'b0;
        for (int unsigned i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check($sformatf("fill_rs1_x%0d", i), rs1_data, pattern(i));
            check($sformatf("fill_rs2_x%0d", 31 - i), rs2_data, pattern(31 - i));
        end
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #1;
        check("fill_x0_rs1", rs1_data, 32'h0);
        check("fill_x0_rs2", rs2_data, 32'h0);
        rs1_addr = 5'd17;
        rs2_addr = 5'd17;
        #1;
        check("same_idx_rs1", rs1_data, 32'hA5A5_0011);
        check("same_idx_rs2", rs2_data, 32'hA5A5_0011);

        // Step 6: async reset between edges, concurrent write ignored
        tick();
        rs1_addr     = 5'd7;
        rs2_addr     = 5'd31;
        rd_addr      = 5'd7;
        write_data   = 32'hFFFF_FFFF;
        write_enable = 1'b1;
        #1;
        check("pre_async_rs1", rs1_data, 32'hA5A5_0007);
        rst = 1'b0;
        #1;
        check("async_rst_rs1", rs1_data, 32'h0);
        check("async_rst_rs2", rs2_data, 32'h0);
        tick();
        check("rst_blocks_write", rs1_data, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_release_rs1", rs1_data, 32'h0);
        tick();
        check("first_write_after_rst", rs1_data, 32'hFFFF_FFFF);
        check("other_reg_cleared", rs2_data, 32'h0);
        write_enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
